down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//  Loadable down-counter/one-shot timer: counts from a loaded value to zero, never wraps.
//  Pulses done on terminal count; optional auto-reload gives a periodic tick.
//  Complements the free-running up counter. Used for timeouts, delays and tick generation.
// PARAMETERS
//  WIDTH    8   counter / load value width in bits
// PORTS
//  clk          in   1      system clock, rising-edge
//  reset        in   1      asynchronous, active-high reset
//  load         in   1      load load_value into count and reload register; forces IDLE
//  load_value   in   WIDTH  value captured on load
//  start        in   1      start from IDLE, or resume from PAUSED
//  pause        in   1      freeze count while running
//  reload_en    in   1      1: reload at terminal count and keep running; 0: one-shot
//  count        out  WIDTH  current count (registered)
//  busy         out  1      1 when state is RUN or PAUSED (registered)
//  done         out  1      single-cycle pulse on terminal count (registered)
//  zero         out  1      combinational (count == 0)
// BEHAVIOUR
//  Clocking: single clock clk. Reset is asynchronous and active-high. On reset assertion, with no clock edge:
//   count=0, reload_reg=0, state=IDLE, busy=0, done=0 (so zero=1).
//  States: IDLE, RUN, PAUSED. Input priority each edge: load > pause > start.
//  load (any state): count<=load_value, reload_reg<=load_value, state->IDLE, done<=0.
//   A load in RUN or PAUSED aborts the run; no done is generated.
//  IDLE: start && count!=0 -> RUN; count is unchanged on this edge.
//   start && count==0 -> ignored: stays IDLE, done stays 0.
//  RUN: each edge, count<=count-1.
//   pause -> PAUSED; count holds on that edge, with no decrement.
//   Terminal edge (count==1, no load/pause): done<=1.
//    reload_en=1: count<=reload_reg, stay RUN. count never shows 0; period = reload_reg cycles.
//    reload_en=0: count<=0, state->IDLE.
//   reload_en is sampled only at the terminal edge.
//  PAUSED: count holds. start && !pause -> RUN, decrement resumes on the following edge.
//  Latency: start sampled at edge E0 -> decrements at E1..EN; done=1 and count=0 after EN
//   (N = loaded value). done is high for exactly one cycle, except reload_reg==1 with reload_en=1,
//   where done stays high every cycle.
//  Width/arithmetic: modulo-2^WIDTH decrement, but the 0 -> all-ones transition is unreachable
//   because count==0 is never decremented. load_value = 2^WIDTH-1 is legal.
//  busy = (state != IDLE), registered from the next-state logic.
//  Simultaneous load+start: load wins, state=IDLE; start must be reasserted.
// STRUCTURE
//  Single module; no natural sub-module.
//  Shared include counter_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSED=2'd2
//   and the default WIDTH constant, shared with the up counter and its bench.
//  Internal state: 2-bit state register, WIDTH-bit reload_reg. Next-state logic and
//   count datapath in separate always blocks.
// TESTING
//  1. load 5, start -> count 4,3,2,1,0 on successive edges; done=1 exactly with count=0; busy 1->0 same edge.
//  2. reload_en=1, load 3, start -> count 2,1,3,2,1,3...; done pulses every 3rd cycle; zero never 1.
//  3. Running, count=4, pause for 3 cycles -> count holds 4, busy=1; start -> 3 on the next edge.
//  4. Running, count=6, load with load_value=9 -> count=9, IDLE, busy=0, no done pulse.
//  5. After reset (count=0), start -> ignored: busy=0, done=0. load 0 then start -> same.
//  6. Async reset mid-run (count=7), between clock edges -> count=0, busy=0, done=0 immediately.
//     Also load 8'hFF, run to 0: 255 decrements, no wrap.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter timer: state encodings and default width.
// State values match the encodings used by the companion up counter.
package down_counter_timer_pkg;

  localparam int DCT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down-counter timer; master drives controls, slave is the timer.
// zero is combinational from count; everything else the timer returns is registered.
interface down_counter_timer_if
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DCT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             reload_en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_value, start, pause, reload_en,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_value, start, pause, reload_en,
    output count, busy, done, zero
  );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter / one-shot timer with optional auto-reload; never wraps through zero.
// start at edge E0 -> decrements on E1..EN, done pulses with count==0 after EN; no backpressure.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DCT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  down_counter_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             busy_q;
  logic             done_q, done_nxt;

  // Priority per edge: load > pause > start.
  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    done_nxt   = 1'b0;

    if (bus.load) begin
      count_nxt  = bus.load_value;
      reload_nxt = bus.load_value;
      state_nxt  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.pause && bus.start && (count_q != '0)) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_nxt = ST_PAUSED;
          end else if (count_q == ONE) begin
            done_nxt = 1'b1;
            if (bus.reload_en) begin
              count_nxt = reload_q;
            end else begin
              count_nxt = '0;
              state_nxt = ST_IDLE;
            end
          end else if (count_q == '0) begin
            // Unreachable in normal use; refuse to wrap and fall back to idle.
            state_nxt = ST_IDLE;
          end else begin
            count_nxt = count_q - ONE;
          end
        end
        ST_PAUSED: begin
          if (bus.start && !bus.pause) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: one task per scenario, inline checks, single summary line.
module tb_down_counter_timer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  down_counter_timer_if #(.WIDTH(8)) dif ();

  down_counter_timer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so samples and drives sit away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    dif.load       = 1'b1;
    dif.load_value = v;
    tick();
    dif.load       = 1'b0;
  endtask

  task automatic do_start();
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_tests++; if (dif.count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", dif.count); end
    n_tests++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", dif.busy); end
    n_tests++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", dif.done); end
    n_tests++; if (dif.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", dif.zero); end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'd4, 8'd3, 8'd2, 8'd1};
    dif.reload_en = 1'b0;
    do_load(8'd5);
    n_tests++; if (dif.count !== 8'd5 || dif.busy !== 1'b0) begin n_fail++; $display("FAIL oneshot_load: got count=%0d busy=%b expected count=5 busy=0", dif.count, dif.busy); end
    do_start();
    n_tests++; if (dif.count !== 8'd5 || dif.busy !== 1'b1) begin n_fail++; $display("FAIL oneshot_start: got count=%0d busy=%b expected count=5 busy=1", dif.count, dif.busy); end
    foreach (exp_seq[i]) begin
      tick();
      n_tests++; if (dif.count !== exp_seq[i] || dif.busy !== 1'b1 || dif.done !== 1'b0) begin n_fail++; $display("FAIL oneshot_dec%0d: got count=%0d busy=%b done=%b expected count=%0d busy=1 done=0", i, dif.count, dif.busy, dif.done, exp_seq[i]); end
    end
    tick();
    n_tests++; if (dif.count !== 8'd0 || dif.done !== 1'b1 || dif.busy !== 1'b0 || dif.zero !== 1'b1) begin n_fail++; $display("FAIL oneshot_terminal: got count=%0d done=%b busy=%b zero=%b expected 0 1 0 1", dif.count, dif.done, dif.busy, dif.zero); end
    tick();
    n_tests++; if (dif.count !== 8'd0 || dif.done !== 1'b0) begin n_fail++; $display("FAIL oneshot_after: got count=%0d done=%b expected count=0 done=0", dif.count, dif.done); end
  endtask

  task automatic test_reload();
    logic [7:0] exp_seq [9];
    exp_seq = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
    dif.reload_en = 1'b1;
    do_load(8'd3);
    do_start();
    foreach (exp_seq[i]) begin
      tick();
      n_tests++; if (dif.count !== exp_seq[i] || dif.done !== (exp_seq[i] == 8'd3) || dif.zero !== 1'b0 || dif.busy !== 1'b1) begin n_fail++; $display("FAIL reload_step%0d: got count=%0d done=%b zero=%b busy=%b expected count=%0d done=%b zero=0 busy=1", i, dif.count, dif.done, dif.zero, dif.busy, exp_seq[i], (exp_seq[i] == 8'd3)); end
    end
    dif.reload_en = 1'b0;
    do_load(8'd0);
  endtask

  task automatic test_pause();
    do_load(8'd8);
    do_start();
    repeat (4) tick();
    n_tests++; if (dif.count !== 8'd4) begin n_fail++; $display("FAIL pause_pre: got count=%0d expected 4", dif.count); end
    dif.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (dif.count !== 8'd4 || dif.busy !== 1'b1 || dif.done !== 1'b0) begin n_fail++; $display("FAIL pause_hold%0d: got count=%0d busy=%b done=%b expected count=4 busy=1 done=0", i, dif.count, dif.busy, dif.done); end
    end
    dif.pause = 1'b0;
    do_start();
    n_tests++; if (dif.count !== 8'd4 || dif.busy !== 1'b1) begin n_fail++; $display("FAIL pause_resume_edge: got count=%0d busy=%b expected count=4 busy=1", dif.count, dif.busy); end
    tick();
    n_tests++; if (dif.count !== 8'd3) begin n_fail++; $display("FAIL pause_resume_dec: got count=%0d expected 3", dif.count); end
    do_load(8'd0);
  endtask

  task automatic test_load_abort();
    do_load(8'd8);
    do_start();
    repeat (2) tick();
    n_tests++; if (dif.count !== 8'd6) begin n_fail++; $display("FAIL abort_pre: got count=%0d expected 6", dif.count); end
    do_load(8'd9);
    n_tests++; if (dif.count !== 8'd9 || dif.busy !== 1'b0 || dif.done !== 1'b0) begin n_fail++; $display("FAIL abort_load: got count=%0d busy=%b done=%b expected count=9 busy=0 done=0", dif.count, dif.busy, dif.done); end
    repeat (3) tick();
    n_tests++; if (dif.count !== 8'd9 || dif.busy !== 1'b0 || dif.done !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got count=%0d busy=%b done=%b expected count=9 busy=0 done=0", dif.count, dif.busy, dif.done); end
  endtask

  task automatic test_zero_start();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    do_start();
    n_tests++; if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.count !== 8'd0) begin n_fail++; $display("FAIL zstart_reset: got busy=%b done=%b count=%0d expected 0 0 0", dif.busy, dif.done, dif.count); end
    do_load(8'd0);
    do_start();
    tick();
    n_tests++; if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.count !== 8'd0) begin n_fail++; $display("FAIL zstart_load0: got busy=%b done=%b count=%0d expected 0 0 0", dif.busy, dif.done, dif.count); end
    dif.start = 1'b1;
    do_load(8'd5);
    dif.start = 1'b0;
    tick();
    n_tests++; if (dif.busy !== 1'b0 || dif.count !== 8'd5) begin n_fail++; $display("FAIL load_beats_start: got busy=%b count=%0d expected busy=0 count=5", dif.busy, dif.count); end
  endtask

  task automatic test_async_reset();
    do_load(8'd10);
    do_start();
    repeat (3) tick();
    n_tests++; if (dif.count !== 8'd7 || dif.busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got count=%0d busy=%b expected count=7 busy=1", dif.count, dif.busy); end
    #1;
    reset = 1'b1;
    #1;
    n_tests++; if (dif.count !== 8'd0 || dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.zero !== 1'b1) begin n_fail++; $display("FAIL areset_now: got count=%0d busy=%b done=%b zero=%b expected 0 0 0 1", dif.count, dif.busy, dif.done, dif.zero); end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_full_range();
    int bad;
    bad = 0;
    do_load(8'hFF);
    do_start();
    for (int i = 1; i < 255; i++) begin
      tick();
      n_tests++; if (dif.count !== 8'(255 - i) || dif.done !== 1'b0 || dif.busy !== 1'b1) begin n_fail++; bad++; if (bad < 4) $display("FAIL full_dec%0d: got count=%0d done=%b busy=%b expected count=%0d done=0 busy=1", i, dif.count, dif.done, dif.busy, 255 - i); end
    end
    tick();
    n_tests++; if (dif.count !== 8'd0 || dif.done !== 1'b1 || dif.busy !== 1'b0) begin n_fail++; $display("FAIL full_terminal: got count=%0d done=%b busy=%b expected 0 1 0", dif.count, dif.done, dif.busy); end
    repeat (2) tick();
    n_tests++; if (dif.count !== 8'd0 || dif.done !== 1'b0) begin n_fail++; $display("FAIL full_nowrap: got count=%0d done=%b expected count=0 done=0", dif.count, dif.done); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    dif.load       = 1'b0;
    dif.load_value = 8'd0;
    dif.start      = 1'b0;
    dif.pause      = 1'b0;
    dif.reload_en  = 1'b0;
    test_reset();
    test_one_shot();
    test_reload();
    test_pause();
    test_load_abort();
    test_zero_start();
    test_async_reset();
    test_full_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
